// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices, FSM states,
// default divide latency and the per-hazard pause/flush stage masks.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned NSTAGE      = 5;
   localparam int unsigned DIV_LAT_DEF = 34;

   localparam int unsigned STG_PC    = 0;
   localparam int unsigned STG_IFID  = 1;
   localparam int unsigned STG_IDEX  = 2;
   localparam int unsigned STG_EXMEM = 3;
   localparam int unsigned STG_MEMWB = 4;

   localparam logic [31:0] INIT_32 = '0;

   typedef enum logic [1:0] {
      ST_RUN = 2'd0,
      ST_DIV = 2'd1,
      ST_MEM = 2'd2
   } hz_state_e;

   typedef logic [NSTAGE-1:0] stg_mask_t;

   // Each hazard freezes everything upstream of the stalled stage and bubbles the stage after it.
   localparam stg_mask_t MEM_PAUSE = 5'b01111;
   localparam stg_mask_t MEM_FLUSH = 5'b10000;
   localparam stg_mask_t DIV_PAUSE = 5'b00111;
   localparam stg_mask_t DIV_FLUSH = 5'b01000;
   localparam stg_mask_t BR_FLUSH  = 5'b00110;
   localparam stg_mask_t LU_PAUSE  = 5'b00011;
   localparam stg_mask_t LU_FLUSH  = 5'b00100;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard request / stage control bundle between the datapath (master) and the
// hazard controller (slave).
interface pipe_hazard_ctrl_if;
   import pipe_hazard_ctrl_pkg::*;

   logic      load_use;
   logic      div_start;
   logic      mem_req;
   logic      mem_rdy;
   logic      br_taken;
   stg_mask_t pause;
   stg_mask_t flush;
   logic      div_done;
   logic      busy;

   modport master (
      output load_use, div_start, mem_req, mem_rdy, br_taken,
      input  pause, flush, div_done, busy
   );

   modport slave (
      input  load_use, div_start, mem_req, mem_rdy, br_taken,
      output pause, flush, div_done, busy
   );

endinterface

// File: rtl/pipe_hazard_ctrl_div_lat_timer.sv
// Divide latency timer: loads LOAD on request, then counts down every cycle and
// saturates at zero; zero flags that the divide result is ready.
module div_lat_timer #(
   parameter int unsigned W    = 6,
   parameter int unsigned LOAD = 33
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= W'(LOAD);
      else if (cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer. Optional HAZARD_PERF_EN adds stall_cycles and
// flush_cnt performance counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [15:0] flush_cnt
`endif
);

   localparam int unsigned CW = $clog2(DIV_LAT);

   hz_state_e state, state_nxt;
   stg_mask_t pause_c, flush_c;
   logic      mem_wait;
   logic      div_load;
   logic      div_zero;
   logic      div_done_c;

   div_lat_timer #(
      .W    (CW),
      .LOAD (DIV_LAT - 1)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (div_load),
      .zero (div_zero)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      pause_c    = '0;
      flush_c    = '0;
      div_load   = 1'b0;
      div_done_c = 1'b0;
      mem_wait   = hz.mem_req && !hz.mem_rdy;

      unique case (state)
         ST_RUN: begin
            if (mem_wait) begin
               pause_c   = MEM_PAUSE;
               flush_c   = MEM_FLUSH;
               state_nxt = ST_MEM;
            end else if (hz.div_start) begin
               pause_c   = DIV_PAUSE;
               flush_c   = DIV_FLUSH;
               div_load  = 1'b1;
               state_nxt = ST_DIV;
            end else if (hz.br_taken) begin
               flush_c = BR_FLUSH;
            end else if (hz.load_use) begin
               pause_c = LU_PAUSE;
               flush_c = LU_FLUSH;
            end
         end
         // Timer keeps running under a memory wait, so a finished divide simply
         // waits in this state for the wait to clear before reporting done.
         ST_DIV: begin
            if (mem_wait) begin
               pause_c = MEM_PAUSE;
               flush_c = MEM_FLUSH;
            end else if (!div_zero) begin
               pause_c = DIV_PAUSE;
               flush_c = DIV_FLUSH;
            end else begin
               div_done_c = 1'b1;
               state_nxt  = ST_RUN;
            end
         end
         ST_MEM: begin
            if (mem_wait) begin
               pause_c = MEM_PAUSE;
               flush_c = MEM_FLUSH;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase

      if (rst) begin
         pause_c    = '0;
         flush_c    = '0;
         div_load   = 1'b0;
         div_done_c = 1'b0;
      end
   end

   assign hz.pause    = pause_c;
   assign hz.flush    = flush_c;
   assign hz.div_done = div_done_c;
   assign hz.busy     = |pause_c;

`ifdef HAZARD_PERF_EN
   // The branch mask is unique among the hazard patterns, so it identifies branch flushes.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_cnt    <= '0;
      end else begin
         if (|pause_c)
            stall_cycles <= stall_cycles + 32'd1;
         if (flush_c == BR_FLUSH)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule
